unified_memory: RTL
===================

# unified_memory

Memory responder for the multicycle RISC-V core: one byte-addressed, word-organised RAM serving both instruction fetch and load/store traffic, plus a small memory-mapped peripheral window with an LED register and free-running millisecond and microsecond counters. It connects directly to the core's memory port (`wen`, `ra`, `wa`, `wd`, `rd`, `funct3`). It supplies a registered read with one-cycle latency, sub-word byte-lane writes, and load sign/zero extension.

## Interface
- `DEPTH_WORDS`, default 2048: RAM depth in 32-bit words; must be a power of 2.
- `INIT_FILE`, default "": hex image loaded into RAM at elaboration with `$readmemh`; no load when empty.
- `MMIO_BASE`, default 32'hFFFF_0000: base address of the peripheral window, which is 64 KiB and aligned.
- `CLK_HZ`, default 12_000_000: clock frequency; sets the counter prescalers.
- `clk`  in  1  clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `wen`  in  1  write strobe for this cycle.
- `ra`  in  32  read byte address.
- `wa`  in  32  write byte address.
- `wd`  in  32  write data, right-aligned (byte in [7:0], half in [15:0]).
- `funct3`  in  3  access size and sign; applies to both the read and the write in that cycle.
- `rd`  out  32  registered, extended read data.
- `led`  out  32  LED register contents.

## Operation
- Address decode:
  - MMIO when `addr[31:16] == MMIO_BASE[31:16]`; otherwise RAM.
  - RAM word index is `addr[2 +: log2(DEPTH_WORDS)]`; upper bits are ignored, so RAM aliases modulo its size.
- Size and lane rules:
  - Word access ignores `addr[1:0]`.
  - Half access uses `addr[1]` and ignores `addr[0]`.
  - Byte access uses `addr[1:0]`.
  - No misalignment fault exists.
- Writes (`wen=1`):
  - funct3 000 writes byte lane `wa[1:0]` with `wd[7:0]`.
  - funct3 001 writes half lane `wa[1]` with `wd[15:0]`.
  - funct3 010 writes all four lanes.
  - Any other funct3: no write.
- Reads, performed every cycle. `ra[1:0]` and `funct3` are registered together with the read so that extension uses the captured values; the core drives `funct3`=010 during fetch.
  - 000 LB: sign-extend the selected byte.
  - 100 LBU: zero-extend the selected byte.
  - 001 LH: sign-extend the selected half.
  - 101 LHU: zero-extend the selected half.
  - 010 and all other codes: full word.
- MMIO registers, at word offset `addr[15:2]`:
  - 0x0: LED, read/write, byte-lane writes honoured.
  - 0x1: millis, read-only; increments every `CLK_HZ/1000` cycles.
  - 0x2: micros, read-only; increments every `CLK_HZ/1000000` cycles.
  - Writes to read-only or unmapped offsets are ignored.
  - Reads of unmapped offsets return 0.
  - MMIO reads use the same extension rules as RAM.
- Counters are 32 bits, wrap 0xFFFFFFFF→0, and run freely from the two independent prescalers.

## Timing
- Read latency is 1 cycle: `rd` after edge N reflects `ra`/`funct3` sampled at edge N and holds until edge N+1.
- Write takes effect at the edge where `wen=1`.
- Same-word read and write in one cycle is read-first: `rd` returns the pre-write word. The new data is visible on a read issued in the next cycle.
- MMIO counter reads return the value before that edge's increment.
- LED update is visible on `led` one cycle after the write edge.
- Reset behaviour:
  - Reset sets `rd`=0, `led`=0, millis=0, micros=0, both prescalers=0, and the captured funct3/lane=0.
  - RAM contents are not affected by reset.
  - Reset has priority over a concurrent `wen`: no RAM or LED write occurs in a reset cycle.
- Reset asserted mid-access: the pending read result is discarded and `rd`=0 on the next cycle.
- Prescaler wrap: counter increments on the same edge the prescaler returns to 0. The first millis increment occurs `CLK_HZ/1000` cycles after reset deassertion.

## Test plan
- INIT_FILE with word 0 = 0x00500093. `ra`=0, `funct3`=010 for one cycle → `rd`=0x00500093 exactly one cycle later; `rd`=0 during reset.
- SW 0x8899AABB to 0x100, then SB 0x11 to 0x102, then LW 0x100 → 0x8811AABB. Then:
  - LB 0x103 → 0xFFFFFF88.
  - LBU 0x103 → 0x00000088.
  - LH 0x102 → 0xFFFF8811.
  - LHU 0x100 → 0x0000AABB.
- Same cycle: SW 0xDEADBEEF to 0x40 and LW from 0x40, with old word 0x12345678 → `rd`=0x12345678; next-cycle LW 0x40 → 0xDEADBEEF.
- Write SH 0xBEEF with `funct3`=011 to 0x80 → no change. SW to 0x80 + 4·`DEPTH_WORDS` → readable at 0x80 (aliasing).
- Peripheral window:
  - SW 0x000000A5 to `MMIO_BASE` → `led`=0xA5 the next cycle.
  - SW to `MMIO_BASE`+4 → ignored.
  - LW `MMIO_BASE`+0x10 → 0.
- `CLK_HZ`=2000:
  - Millis reads 0 before cycle 2 and 1 after 2 cycles, and keeps counting.
  - Reset asserted with `wen`=1 to LED → `led` stays 0 and both counters return to 0.

Source files
------------

// File: rtl/unified_memory_if.sv
// rtl/unified_memory_if.sv - core-side memory port bundle for unified_memory
interface unified_memory_if;
  logic        wen;
  logic [31:0] ra;
  logic [31:0] wa;
  logic [31:0] wd;
  logic [2:0]  funct3;
  logic [31:0] rd;
  logic [31:0] led;

  modport master (output wen, ra, wa, wd, funct3, input rd, led);
  modport slave  (input wen, ra, wa, wd, funct3, output rd, led);
endinterface

// File: rtl/unified_memory.sv
// rtl/unified_memory.sv - shared instruction/data RAM with LED and ms/us counter window
module unified_memory #(
  parameter int unsigned DEPTH_WORDS = 2048,
  parameter string       INIT_FILE   = "",
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter int unsigned CLK_HZ      = 12_000_000
) (
  input  logic              clk,
  input  logic              reset,
  unified_memory_if.slave   bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  // Clocks below 1 MHz would give a zero divider; clamp so the counter still ticks each cycle.
  localparam int unsigned MS_DIV = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int unsigned US_DIV = (CLK_HZ / 1000000 > 0) ? CLK_HZ / 1000000 : 1;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] ms_pre, us_pre, millis, micros, led_q;
  logic [31:0] raw_q, mmio_rdata, wlanes, rd_ext;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [3:0]  be;
  logic        r_mmio, w_mmio;
  logic [AW-1:0] ridx, widx;

  assign r_mmio = (bus.ra[31:16] == MMIO_BASE[31:16]);
  assign w_mmio = (bus.wa[31:16] == MMIO_BASE[31:16]);
  assign ridx   = bus.ra[2 +: AW];
  assign widx   = bus.wa[2 +: AW];

  always_comb begin
    be     = 4'b0000;
    wlanes = bus.wd;
    if (bus.wen) begin
      case (bus.funct3)
        3'b000: begin
          be     = 4'b0001 << bus.wa[1:0];
          wlanes = {4{bus.wd[7:0]}};
        end
        3'b001: begin
          be     = bus.wa[1] ? 4'b1100 : 4'b0011;
          wlanes = {2{bus.wd[15:0]}};
        end
        3'b010:  be = 4'b1111;
        default: be = 4'b0000;
      endcase
    end
  end

  // RAM write is gated by reset; read-first falls out of the nonblocking update.
  always_ff @(posedge clk) begin
    if (!reset && !w_mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q <= 32'd0;
    end else if (w_mmio && bus.wa[15:2] == 14'd0) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) led_q[8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_pre <= 32'd0;
      us_pre <= 32'd0;
      millis <= 32'd0;
      micros <= 32'd0;
    end else begin
      if (ms_pre == 32'(MS_DIV - 1)) begin
        ms_pre <= 32'd0;
        millis <= millis + 32'd1;
      end else begin
        ms_pre <= ms_pre + 32'd1;
      end
      if (us_pre == 32'(US_DIV - 1)) begin
        us_pre <= 32'd0;
        micros <= micros + 32'd1;
      end else begin
        us_pre <= us_pre + 32'd1;
      end
    end
  end

  always_comb begin
    case (bus.ra[15:2])
      14'd0:   mmio_rdata = led_q;
      14'd1:   mmio_rdata = millis;
      14'd2:   mmio_rdata = micros;
      default: mmio_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      raw_q  <= 32'd0;
      f3_q   <= 3'd0;
      lane_q <= 2'd0;
    end else begin
      raw_q  <= r_mmio ? mmio_rdata : mem[ridx];
      f3_q   <= bus.funct3;
      lane_q <= bus.ra[1:0];
    end
  end

  // Extension works on the captured lane/size so rd is stable for the whole cycle.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = raw_q[8*lane_q +: 8];
    h = lane_q[1] ? raw_q[31:16] : raw_q[15:0];
    case (f3_q)
      3'b000:  rd_ext = {{24{b[7]}}, b};
      3'b100:  rd_ext = {24'd0, b};
      3'b001:  rd_ext = {{16{h[15]}}, h};
      3'b101:  rd_ext = {16'd0, h};
      default: rd_ext = raw_q;
    endcase
  end

  assign bus.rd  = rd_ext;
  assign bus.led = led_q;
endmodule
